// File: rtl/wb_pkg.sv
// Shared types for the writeback scheduler: requester names, write-request bundle
// and the hardwired-zero GPR address.
package wb_pkg;

  localparam int WB_XLEN = 32;
  localparam int WB_AW   = 5;

  localparam logic [WB_AW-1:0] GPR_ZERO = 5'd0;

  typedef enum logic [1:0] {
    REQ_LD,
    REQ_ALU,
    REQ_FPU,
    REQ_MOV
  } req_e;

  typedef struct packed {
    logic               valid;
    logic [WB_AW-1:0]   rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arb.sv
// One register-file write port: fixed-priority pick of three requesters
// (req0 > req1 > req2, or req2 first when promoted) and a one-cycle output register.
module wb_port_arb
  import wb_pkg::*;
#(
  parameter bit ZERO_NOP = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  input  wb_req_t            req0,
  input  wb_req_t            req1,
  input  wb_req_t            req2,
  input  logic               promote,
  output logic [2:0]         grant,
  output logic               we,
  output logic [WB_AW-1:0]   waddr,
  output logic [WB_XLEN-1:0] wdata,
  output logic               finish
);

  wb_req_t sel;
  logic    xfer;

  // Valid/ready: grant is the ready of each requester and is only raised for a
  // valid request, so any grant bit set means a transfer happens this cycle.
  always_comb begin
    grant = 3'b000;
    if (!rstn) begin
      grant = 3'b000;
    end else if (promote && req2.valid) begin
      grant = 3'b100;
    end else if (req0.valid) begin
      grant = 3'b001;
    end else if (req1.valid) begin
      grant = 3'b010;
    end else if (req2.valid) begin
      grant = 3'b100;
    end
  end

  always_comb begin
    sel = '0;
    unique case (grant)
      3'b001:  sel = req0;
      3'b010:  sel = req1;
      3'b100:  sel = req2;
      default: sel = '0;
    endcase
  end

  assign xfer = |grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we     <= 1'b0;
      finish <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      finish <= xfer;
      // A write to the hardwired-zero register retires without touching the file.
      we     <= xfer && !(ZERO_NOP && sel.rd == GPR_ZERO);
      if (xfer) begin
        waddr <= sel.rd;
        wdata <= sel.data;
      end
    end
  end

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler owning the GPR and FPR write ports, with MOV anti-starvation.
// Optional issue-side scoreboard is compiled in with WB_SCOREBOARD_EN.
module wb_sched
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            fpu_valid,
  output logic            fpu_ready,
  input  logic [4:0]      fpu_rd,
  input  logic [XLEN-1:0] fpu_data,
  input  logic            mov_valid,
  output logic            mov_ready,
  input  logic [4:0]      mov_rd,
  input  logic [XLEN-1:0] mov_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_fp,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            gpr_we,
  output logic [4:0]      gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            fpr_we,
  output logic [4:0]      fpr_waddr,
  output logic [XLEN-1:0] fpr_wdata,
  output logic            gpr_finish,
  output logic            fpr_finish,
  input  logic            iss_valid,
  input  logic            iss_fp,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  output logic [NREG-1:0] gpr_busy,
  output logic [NREG-1:0] fpr_busy
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_LIMIT);

  wb_req_t    ld_gpr_req, alu_req, ld_fpr_req, fpu_req, mov_req;
  logic [2:0] gpr_grant, fpr_grant;
  logic [1:0] starve_cnt;
  logic       promote;
  logic       unused_gpr_grant;

  always_comb begin
    ld_gpr_req = '{valid: ld_valid && !ld_fp, rd: ld_rd, data: ld_data};
    alu_req    = '{valid: alu_valid,          rd: alu_rd, data: alu_data};
    ld_fpr_req = '{valid: ld_valid && ld_fp,  rd: ld_rd, data: ld_data};
    fpu_req    = '{valid: fpu_valid,          rd: fpu_rd, data: fpu_data};
    mov_req    = '{valid: mov_valid,          rd: mov_rd, data: mov_data};
  end

  // Consecutive-denial counter for MOV; saturates so it cannot wrap back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 2'd0;
    end else if (!mov_valid || mov_ready) begin
      starve_cnt <= 2'd0;
    end else if (starve_cnt != 2'd3) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end

  assign promote = (starve_cnt >= STARVE_LIM);

  wb_port_arb #(.ZERO_NOP(1'b1)) u_gpr_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req0    (ld_gpr_req),
    .req1    (alu_req),
    .req2    ('0),
    .promote (1'b0),
    .grant   (gpr_grant),
    .we      (gpr_we),
    .waddr   (gpr_waddr),
    .wdata   (gpr_wdata),
    .finish  (gpr_finish)
  );

  wb_port_arb #(.ZERO_NOP(1'b0)) u_fpr_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req0    (ld_fpr_req),
    .req1    (fpu_req),
    .req2    (mov_req),
    .promote (promote),
    .grant   (fpr_grant),
    .we      (fpr_we),
    .waddr   (fpr_waddr),
    .wdata   (fpr_wdata),
    .finish  (fpr_finish)
  );

  assign alu_ready        = gpr_grant[1];
  assign ld_ready         = gpr_grant[0] | fpr_grant[0];
  assign fpu_ready        = fpr_grant[1];
  assign mov_ready        = fpr_grant[2];
  assign unused_gpr_grant = gpr_grant[2];

`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] gpr_set, gpr_clr, fpr_set, fpr_clr;

  always_comb begin
    iss_ready = iss_fp ? !fpr_busy[iss_rd]
                       : (iss_rd == GPR_ZERO) || !gpr_busy[iss_rd];
  end

  // The retiring write clears its bit; an issue landing on the same edge wins.
  always_comb begin
    gpr_set = '0;
    fpr_set = '0;
    gpr_clr = '0;
    fpr_clr = '0;
    if (iss_valid && iss_ready) begin
      if (iss_fp)                    fpr_set[iss_rd] = 1'b1;
      else if (iss_rd != GPR_ZERO)   gpr_set[iss_rd] = 1'b1;
    end
    if (gpr_finish) gpr_clr[gpr_waddr] = 1'b1;
    if (fpr_finish) fpr_clr[fpr_waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpr_busy <= '0;
      fpr_busy <= '0;
    end else begin
      gpr_busy <= (gpr_busy & ~gpr_clr) | gpr_set;
      fpr_busy <= (fpr_busy & ~fpr_clr) | fpr_set;
    end
  end
`else
  logic unused_iss;

  assign unused_iss = ^{iss_valid, iss_fp, iss_rd};
  assign iss_ready  = 1'b1;
  assign gpr_busy   = '0;
  assign fpr_busy   = '0;
`endif

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: a per-cycle reference model of the port priorities,
// MOV promotion, one-cycle write latency and scoreboard, plus literal spot checks.
module tb_wb_sched;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int STARVE = 3;
`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic            clk, rstn;
  logic            alu_valid, alu_ready, fpu_valid, fpu_ready;
  logic            mov_valid, mov_ready, ld_valid, ld_ready, ld_fp;
  logic [4:0]      alu_rd, fpu_rd, mov_rd, ld_rd;
  logic [XLEN-1:0] alu_data, fpu_data, mov_data, ld_data;
  logic            gpr_we, fpr_we, gpr_finish, fpr_finish;
  logic [4:0]      gpr_waddr, fpr_waddr;
  logic [XLEN-1:0] gpr_wdata, fpr_wdata;
  logic            iss_valid, iss_fp, iss_ready;
  logic [4:0]      iss_rd;
  logic [NREG-1:0] gpr_busy, fpr_busy;

  int total = 0;
  int bad   = 0;

  // Expected retiring writes, {we, addr, data}, one entry per accepted request.
  logic [37:0] gpr_exp_q[$];
  logic [37:0] fpr_exp_q[$];
  int          m_starve;
  logic [NREG-1:0] m_gbusy, m_fbusy;

  wb_sched #(.XLEN(XLEN), .NREG(NREG), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
    .mov_valid(mov_valid), .mov_ready(mov_ready), .mov_rd(mov_rd), .mov_data(mov_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_fp(ld_fp), .ld_rd(ld_rd), .ld_data(ld_data),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .fpr_we(fpr_we), .fpr_waddr(fpr_waddr), .fpr_wdata(fpr_wdata),
    .gpr_finish(gpr_finish), .fpr_finish(fpr_finish),
    .iss_valid(iss_valid), .iss_fp(iss_fp), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .gpr_busy(gpr_busy), .fpr_busy(fpr_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + compare ----------------
  always @(negedge clk) begin : compare
    logic [37:0]     e;
    logic [NREG-1:0] gclr, fclr, gset, fset;
    logic            g_ld, g_alu, f_ld, f_fpu, f_mov, prom, exp_iss;
    if (!rstn) begin
      gpr_exp_q.delete();
      fpr_exp_q.delete();
      m_starve = 0;
      m_gbusy  = '0;
      m_fbusy  = '0;
      chk("rst_gpr_port", {gpr_we, gpr_finish, gpr_waddr, gpr_wdata}, '0);
      chk("rst_fpr_port", {fpr_we, fpr_finish, fpr_waddr, fpr_wdata}, '0);
      chk("rst_ready", {alu_ready, ld_ready, fpu_ready, mov_ready}, '0);
      chk("rst_busy", {gpr_busy, fpr_busy}, '0);
    end else begin
      gclr = '0;
      fclr = '0;
      if (gpr_exp_q.size() != 0) begin
        e = gpr_exp_q.pop_front();
        chk("gpr_finish", gpr_finish, 1);
        chk("gpr_we", gpr_we, e[37]);
        if (e[37]) begin
          chk("gpr_waddr", gpr_waddr, e[36:32]);
          chk("gpr_wdata", gpr_wdata, e[31:0]);
        end
        gclr[e[36:32]] = 1'b1;
      end else begin
        chk("gpr_idle", {gpr_finish, gpr_we}, 0);
      end
      if (fpr_exp_q.size() != 0) begin
        e = fpr_exp_q.pop_front();
        chk("fpr_finish", fpr_finish, 1);
        chk("fpr_we", fpr_we, 1);
        chk("fpr_waddr", fpr_waddr, e[36:32]);
        chk("fpr_wdata", fpr_wdata, e[31:0]);
        fclr[e[36:32]] = 1'b1;
      end else begin
        chk("fpr_idle", {fpr_finish, fpr_we}, 0);
      end

      // GPR port: a GPR load beats the ALU.
      g_ld  = ld_valid && !ld_fp;
      g_alu = alu_valid && !g_ld;
      // FPR port: promoted MOV > FPR load > FPU > MOV.
      prom  = mov_valid && (m_starve >= STARVE);
      f_ld  = ld_valid && ld_fp && !prom;
      f_fpu = fpu_valid && !prom && !f_ld;
      f_mov = mov_valid && (prom || (!f_ld && !f_fpu));
      chk("ready", {alu_ready, ld_ready, fpu_ready, mov_ready},
          {g_alu, g_ld || f_ld, f_fpu, f_mov});

      if (g_ld)  gpr_exp_q.push_back({ld_rd != 0, ld_rd, ld_data});
      if (g_alu) gpr_exp_q.push_back({alu_rd != 0, alu_rd, alu_data});
      if (f_ld)  fpr_exp_q.push_back({1'b1, ld_rd, ld_data});
      if (f_fpu) fpr_exp_q.push_back({1'b1, fpu_rd, fpu_data});
      if (f_mov) fpr_exp_q.push_back({1'b1, mov_rd, mov_data});

      if (mov_valid && !f_mov) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
      else                     m_starve = 0;

`ifdef WB_SCOREBOARD_EN
      exp_iss = iss_fp ? !m_fbusy[iss_rd] : (iss_rd == 0) || !m_gbusy[iss_rd];
      chk("iss_ready", iss_ready, exp_iss);
      chk("gpr_busy", gpr_busy, m_gbusy);
      chk("fpr_busy", fpr_busy, m_fbusy);
      gset = '0;
      fset = '0;
      if (iss_valid && exp_iss) begin
        if (iss_fp)           fset[iss_rd] = 1'b1;
        else if (iss_rd != 0) gset[iss_rd] = 1'b1;
      end
      m_gbusy = (m_gbusy & ~gclr) | gset;
      m_fbusy = (m_fbusy & ~fclr) | fset;
`else
      exp_iss = 1'b1;
      gset = gclr;
      fset = fclr;
      chk("iss_ready", iss_ready, exp_iss);
      chk("busy_off", {gpr_busy, fpr_busy}, '0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    fpu_valid = 0; fpu_rd = 0; fpu_data = 0;
    mov_valid = 0; mov_rd = 0; mov_data = 0;
    ld_valid = 0; ld_fp = 0; ld_rd = 0; ld_data = 0;
    iss_valid = 0; iss_fp = 0; iss_rd = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1; alu_rd = rd; alu_data = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_inputs();
    rstn = 1;
    #2 rstn = 0;
    @(negedge clk);
    chk("lit_reset_we", {gpr_we, fpr_we}, 0);
    repeat (2) tick();
    rstn = 1;

    // ALU r5 = 0x1234: write appears one cycle after the transfer, for one cycle.
    tick(); alu(5, 32'h1234);
    @(negedge clk); chk("lit_alu_ready", alu_ready, 1);
    tick(); alu_valid = 0;
    @(negedge clk);
    chk("lit_alu_write", {gpr_we, gpr_finish, gpr_waddr, gpr_wdata}, {1'b1, 1'b1, 5'd5, 32'h1234});
    tick();
    @(negedge clk); chk("lit_alu_once", {gpr_we, gpr_finish}, 0);

    // LD(gpr) r8 and ALU r7 together: load first, ALU next cycle.
    tick(); alu(7, 32'hA7); ld_valid = 1; ld_fp = 0; ld_rd = 8; ld_data = 32'hB8;
    @(negedge clk); chk("lit_ld_first", {ld_ready, alu_ready}, 2'b10);
    tick(); ld_valid = 0;
    @(negedge clk); chk("lit_ld_write", {gpr_finish, gpr_waddr}, {1'b1, 5'd8});
    tick(); alu_valid = 0;
    @(negedge clk); chk("lit_alu7_write", {gpr_finish, gpr_waddr, gpr_wdata}, {1'b1, 5'd7, 32'hA7});
    tick();

    // FPU always valid, MOV r3 waiting: MOV wins on its 4th cycle.
    tick();
    fpu_valid = 1; fpu_rd = 1; fpu_data = 32'h100;
    mov_valid = 1; mov_rd = 3; mov_data = 32'h3FC0_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("lit_mov_denied", mov_ready, 0);
      tick(); fpu_data = 32'h101 + 32'(i);
    end
    @(negedge clk); chk("lit_mov_promoted", {mov_ready, fpu_ready}, 2'b10);
    tick(); mov_valid = 0;
    @(negedge clk);
    chk("lit_mov_write", {fpr_we, fpr_waddr, fpr_wdata}, {1'b1, 5'd3, 32'h3FC0_0000});
    tick(); fpu_valid = 0;
    tick();

    // ALU r0: retires without a write enable.
    tick(); alu(0, 32'hFFFF);
    tick(); alu_valid = 0;
    @(negedge clk); chk("lit_r0", {gpr_finish, gpr_we, gpr_busy}, {1'b1, 1'b0, 32'h0});

    // FPR load over FPU, GPR port busy in parallel.
    tick(); alu(12, 32'hE0); fpu_valid = 1; fpu_rd = 11; fpu_data = 32'hD0;
    ld_valid = 1; ld_fp = 1; ld_rd = 10; ld_data = 32'hC0;
    @(negedge clk); chk("lit_ldfp_first", {alu_ready, ld_ready, fpu_ready}, 3'b110);
    tick(); ld_valid = 0; alu_valid = 0;
    @(negedge clk); chk("lit_parallel", {gpr_waddr, fpr_waddr}, {5'd12, 5'd10});
    tick(); fpu_valid = 0;
    tick();

    // Back-to-back traffic on both ports; FPU holds its request while loads win.
    for (int i = 0; i < 6; i++) begin
      tick();
      alu(5'(16 + i), 32'h11 * 32'(i));
      ld_valid = 1; ld_fp = 1; ld_rd = 5'(20 + i); ld_data = 32'h5000 + 32'(i);
      fpu_valid = 1; fpu_rd = 30; fpu_data = 32'hF00D;
    end
    tick(); alu_valid = 0; ld_valid = 0;
    tick(); fpu_valid = 0;
    tick();

    // Scoreboard: reserve FPR r9, WAW stall, clear by FPU write.
    tick(); iss_valid = 1; iss_fp = 1; iss_rd = 9;
    @(negedge clk); chk("lit_iss_r9", iss_ready, 1);
    tick(); fpu_valid = 1; fpu_rd = 9; fpu_data = 32'h99;
    @(negedge clk); chk("lit_busy9", {fpr_busy[9], iss_ready}, {SB, !SB});
    tick(); fpu_valid = 0;
    @(negedge clk); chk("lit_busy9_hold", {fpr_we, fpr_busy[9], iss_ready}, {1'b1, SB, !SB});
    tick();
    @(negedge clk); chk("lit_busy9_clear", {fpr_busy[9], iss_ready}, 2'b01);
    tick(); iss_valid = 0; fpu_valid = 1; fpu_rd = 9; fpu_data = 32'h9A;
    tick(); fpu_valid = 0;
    tick();

    // Set and clear of GPR r4 on one edge: set wins.
    tick(); alu(4, 32'h44);
    tick(); alu_valid = 0; iss_valid = 1; iss_fp = 0; iss_rd = 4;
    tick(); iss_valid = 0;
    @(negedge clk); chk("lit_set_wins", gpr_busy[4], SB);
    tick(); alu(4, 32'h45);
    tick(); alu_valid = 0;
    tick();

    // Issuing GPR r0 is always ready and reserves nothing.
    tick(); iss_valid = 1; iss_fp = 0; iss_rd = 0;
    @(negedge clk); chk("lit_iss_r0", iss_ready, 1);
    tick(); iss_valid = 0;
    @(negedge clk); chk("lit_r0_nobusy", gpr_busy, 0);

    // Reset right after an ALU transfer drops the pending write.
    tick(); alu(6, 32'h66);
    tick(); alu_valid = 0; rstn = 0;
    @(negedge clk); chk("lit_rst_drop", {gpr_we, gpr_finish}, 0);
    repeat (2) tick();
    rstn = 1;
    tick(); alu(2, 32'h22);
    tick(); alu_valid = 0;
    @(negedge clk); chk("lit_resume", {gpr_we, gpr_waddr, gpr_wdata}, {1'b1, 5'd2, 32'h22});
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
